// File: rtl/matrix_result_streamer_if.sv
// Valid/ready beat bus carrying (row, col, value) results from the matrix streamer to its sink.
interface matrix_result_streamer_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 2
);
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  out_row;
  logic [IDX_W-1:0]  out_col;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid, out_row, out_col, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_row, out_col, out_data, out_last,
    output out_ready
  );
endinterface

// File: rtl/matrix_result_streamer.sv
// Snapshots an N x N result array on start and drains it row-major as (row, col, value) beats.
// Define SPARSE_SKIP_ZERO_EN to drop zero elements and emit sparse COO output.
module matrix_result_streamer #(
  parameter  int DATA_W = 8,
  parameter  int N      = 3,
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1,
  localparam int CNT_W  = $clog2(N*N + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic [DATA_W-1:0]      i_mat_in [N*N],
  output logic                   o_busy,
  output logic                   o_done,
  output logic [CNT_W-1:0]       o_beat_count,
  matrix_result_streamer_if.master o_stream
);

  localparam int NN    = N * N;
  localparam int LIN_W = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_snap [NN];
  logic [LIN_W-1:0]  r_idx;
  logic [IDX_W-1:0]  r_row;
  logic [IDX_W-1:0]  r_col;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_last;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_beatCount;

  logic              w_fire;
  logic              w_startAny;
  logic              w_startLast;
  logic              w_nextLast;
  logic [LIN_W-1:0]  w_startIdx;
  logic [LIN_W-1:0]  w_nextIdx;

  function automatic logic [IDX_W-1:0] rowOf(input logic [LIN_W-1:0] idx);
    return IDX_W'(int'(idx) / N);
  endfunction

  function automatic logic [IDX_W-1:0] colOf(input logic [LIN_W-1:0] idx);
    return IDX_W'(int'(idx) % N);
  endfunction

`ifdef SPARSE_SKIP_ZERO_EN
  logic [NN-1:0] w_startMask;
  logic [NN-1:0] w_snapMask;

  function automatic logic [LIN_W-1:0] lowestFrom(input logic [NN-1:0] mask, input int lo);
    logic [LIN_W-1:0] idx;
    idx = '0;
    for (int i = NN - 1; i >= 0; i--) begin
      if (i >= lo && mask[i]) idx = LIN_W'(i);
    end
    return idx;
  endfunction

  function automatic logic anyFrom(input logic [NN-1:0] mask, input int lo);
    logic found;
    found = 1'b0;
    for (int i = 0; i < NN; i++) begin
      if (i >= lo && mask[i]) found = 1'b1;
    end
    return found;
  endfunction

  // Look-ahead on the nonzero masks lets zero elements be skipped without bubbles.
  always_comb begin
    for (int i = 0; i < NN; i++) begin
      w_startMask[i] = (i_mat_in[i] != '0);
      w_snapMask[i]  = (r_snap[i] != '0);
    end
    w_startAny  = |w_startMask;
    w_startIdx  = lowestFrom(w_startMask, 0);
    w_startLast = !anyFrom(w_startMask, int'(w_startIdx) + 1);
    w_nextIdx   = lowestFrom(w_snapMask, int'(r_idx) + 1);
    w_nextLast  = !anyFrom(w_snapMask, int'(w_nextIdx) + 1);
  end
`else
  always_comb begin
    w_startAny  = 1'b1;
    w_startIdx  = '0;
    w_startLast = (NN == 1);
    w_nextIdx   = r_idx + 1'b1;
    w_nextLast  = (int'(r_idx) + 2 == NN);
  end
`endif

  assign w_fire = r_valid & o_stream.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      for (int i = 0; i < NN; i++) r_snap[i] <= '0;
      r_idx       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
      r_beatCount <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_snap <= i_mat_in;
            r_cnt  <= '0;
            // The first beat is taken straight from the input so it appears one cycle after start.
            if (w_startAny) begin
              r_state <= SEND;
              r_busy  <= 1'b1;
              r_valid <= 1'b1;
              r_idx   <= w_startIdx;
              r_row   <= rowOf(w_startIdx);
              r_col   <= colOf(w_startIdx);
              r_data  <= i_mat_in[w_startIdx];
              r_last  <= w_startLast;
            end else begin
              r_state     <= FIN;
              r_done      <= 1'b1;
              r_beatCount <= '0;
            end
          end
        end
        SEND: begin
          if (w_fire) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_last) begin
              r_state     <= FIN;
              r_valid     <= 1'b0;
              r_last      <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_beatCount <= r_cnt + 1'b1;
            end else begin
              r_idx  <= w_nextIdx;
              r_row  <= rowOf(w_nextIdx);
              r_col  <= colOf(w_nextIdx);
              r_data <= r_snap[w_nextIdx];
              r_last <= w_nextLast;
            end
          end
        end
        FIN: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_stream.out_valid = r_valid;
  assign o_stream.out_row   = r_row;
  assign o_stream.out_col   = r_col;
  assign o_stream.out_data  = r_data;
  assign o_stream.out_last  = r_last;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_beat_count       = r_beatCount;

endmodule
